// File: rtl/multicycle_control.sv
// Multi-cycle MIPS32 sequencer: Moore FSM sharing one memory port, ALU and PC adder
// across instruction phases, with memory-ready wait timeout and illegal-opcode trap.
module multicycle_control #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_memto_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic       o_instr_done,
    output logic       o_trap,
    output logic [1:0] o_trap_cause,
    output logic [3:0] o_state
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd15
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_wait_cnt, w_wait_nxt;
    logic       r_trap;
    logic [1:0] r_cause, w_cause_nxt;
    logic       w_waiting, w_timeout;

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                        (r_state == S_MEM_WRITE)) && !i_mem_ready;
    // Last permitted wait cycle: leave for TRAP instead of waiting again
    assign w_timeout = w_waiting && (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
            r_trap     <= 1'b0;
            r_cause    <= 2'b00;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause_nxt;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cause_nxt  = 2'b01;
        w_wait_nxt   = 8'd0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_iord       = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_memto_reg  = 1'b0;
        o_reg_dst    = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 2'b00;
        o_pc_source  = 2'b00;
        o_instr_done = 1'b0;

        if (w_waiting && !w_timeout) begin
            w_wait_nxt = r_wait_cnt + 8'd1;
        end

        if (w_timeout) begin
            w_next      = S_TRAP;
            w_cause_nxt = 2'b10;
        end else begin
            case (r_state)
                S_FETCH: begin
                    o_mem_read  = 1'b1;
                    o_alu_src_b = 2'b01;
                    o_ir_write  = i_mem_ready;
                    o_pc_write  = i_mem_ready;
                    if (i_mem_ready) w_next = S_DECODE;
                end
                S_DECODE: begin
                    o_alu_src_b = 2'b11;
                    case (i_opcode)
                        OP_RTYPE:      w_next = S_EXECUTE;
                        OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: w_next = S_BRANCH;
                        OP_J:          w_next = S_JUMP;
                        OP_ADDI:       w_next = S_ADDI_EXEC;
                        default:       w_next = S_TRAP;
                    endcase
                end
                S_MEM_ADDR: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'b10;
                    w_next      = (i_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    o_mem_read = 1'b1;
                    o_iord     = 1'b1;
                    if (i_mem_ready) w_next = S_MEM_WB;
                end
                S_MEM_WB: begin
                    o_reg_write  = 1'b1;
                    o_memto_reg  = 1'b1;
                    o_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
                S_MEM_WRITE: begin
                    o_mem_write  = 1'b1;
                    o_iord       = 1'b1;
                    o_instr_done = i_mem_ready;
                    if (i_mem_ready) w_next = S_FETCH;
                end
                S_EXECUTE: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = 2'b10;
                    w_next      = S_R_WB;
                end
                S_R_WB: begin
                    o_reg_write  = 1'b1;
                    o_reg_dst    = 1'b1;
                    o_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
                S_BRANCH: begin
                    o_alu_src_a  = 1'b1;
                    o_alu_op     = 2'b01;
                    o_pc_source  = 2'b01;
                    o_pc_write   = (i_opcode == OP_BEQ) ? i_zero : !i_zero;
                    o_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
                S_JUMP: begin
                    o_pc_source  = 2'b10;
                    o_pc_write   = 1'b1;
                    o_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
                S_ADDI_EXEC: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'b10;
                    w_next      = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    o_reg_write  = 1'b1;
                    o_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
                S_TRAP: w_next = S_TRAP;
                default: w_next = S_TRAP;
            endcase
        end
    end

    assign o_trap       = r_trap;
    assign o_trap_cause = r_cause;
    assign o_state      = r_state;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS32 datapath. It replaces the single-cycle control decoder with a Moore state machine that time-multiplexes one memory port, one ALU and the PC adder across instruction phases. It drives every datapath select and write strobe, honours a memory-ready handshake, and traps on illegal opcodes or memory timeout. It sits beside the regfile, ULA and memory, taking opcode and funct from the datapath instruction register.

## Interface
- WAIT_LIMIT, 16, max consecutive cycles a memory state may wait on i_mem_ready before trapping (2..255)
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- i_opcode  in  6  IR[31:26]; stable from DECODE until next FETCH
- i_zero  in  1  ULA zero_flag
- i_mem_ready  in  1  memory completes current access this cycle
- o_ir_write, o_pc_write, o_iord, o_mem_read, o_mem_write, o_memto_reg, o_reg_dst, o_reg_write, o_alu_src_a  out  1 each  datapath strobes/selects
- o_alu_src_b  out  2  00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
- o_alu_op  out  2  00 add, 01 sub, 10 funct-decoded (to alu_decoder)
- o_pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- o_instr_done  out  1  one-cycle pulse in final cycle of each instruction
- o_trap  out  1  sticky; set on entry to TRAP
- o_trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none
- o_state  out  4  current state code (debug)

## Operation
- States/codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, TRAP 15; unused codes go to TRAP with cause 01.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=i_mem_ready. Stay while !i_mem_ready, else DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on i_opcode: 000000 EXECUTE; 100011/101011 MEM_ADDR; 000100/000101 BRANCH; 000010 JUMP; 001000 ADDI_EXEC; other TRAP (cause 01).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw to MEM_READ, sw to MEM_WRITE.
- MEM_READ: mem_read=1, iord=1; wait on ready, then MEM_WB.
- MEM_WB: reg_write=1, memto_reg=1, reg_dst=0; done, then FETCH.
- MEM_WRITE: mem_write=1, iord=1; wait on ready; done on ready cycle, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB.
- R_WB: reg_write=1, reg_dst=1, memto_reg=0; done, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write = i_zero (000100) or !i_zero (000101); done, then FETCH.
- JUMP: pc_source=10, pc_write=1; done, then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, memto_reg=0; done, then FETCH.
- TRAP: all strobes 0; terminal until reset.
- Unlisted outputs are 0 in every state.
- Wait counter: 8-bit; cleared on entering any memory state and while i_mem_ready=1; increments each waiting cycle. At WAIT_LIMIT waiting cycles it goes to TRAP with cause 10, issuing no strobes that cycle.

## Timing
- Outputs are Moore decodes of state, except ir_write/pc_write/o_instr_done in memory states (gated by i_mem_ready) and pc_write in BRANCH (uses i_zero).
- Reset (Rst=0, async): state=FETCH, counter=0, o_trap=0, o_trap_cause=00, o_instr_done=0. Other outputs show the FETCH decode. First fetch completes on the first rising edge after Rst rises with i_mem_ready=1.
- Zero-wait latencies (cycles): R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4. Each wait cycle adds 1.
- Reset mid-instruction aborts immediately; no partial writes after Rst falls.
- i_mem_ready is ignored outside FETCH/MEM_READ/MEM_WRITE.

## Test plan
- Reset then i_opcode=000000, ready=1 -> states 0,1,6,7,0. reg_write=reg_dst=1 in state 7. instr_done pulses once in cycle 4.
- lw (100011) with ready low for 3 cycles in MEM_READ -> 8 cycles total. mem_read=iord=1 throughout MEM_READ. memto_reg=reg_write=1 in MEM_WB.
- beq with i_zero=1, then bne with i_zero=1 -> pc_write=1 with pc_source=01 for beq; pc_write=0 for bne. Both take 3 cycles.
- Opcode 111111 -> TRAP after DECODE. o_trap=1, cause=01, o_state=15, all strobes 0 for 20+ cycles.
- WAIT_LIMIT=4, i_mem_ready held 0 in FETCH -> TRAP on the 4th wait cycle, cause=10, no ir_write.
- Assert Rst in MEM_WRITE -> mem_write drops asynchronously, state=0, o_trap stays 0.
